hwregs_bus_bridge: RTL and testbench

Bridges the CPU data-memory bus to the `hwregs` block at 0xE0000000. It buffers CPU requests, issues them to `hwregs` one per cycle in strict order, and captures every read response in a response FIFO so the CPU may apply backpressure even though `hwregs` cannot be stalled. It sits between the CPU load/store path and `hwregs`, and returns to the CPU the 9-bit tag that `hwregs` echoes.

---
 rtl/hwregs_bridge_pkg.sv | 26 ++
 rtl/bridge_fifo.sv | 65 ++++++
 rtl/hwregs_bus_bridge.sv | 141 ++++++++++++++
 tb/tb_hwregs_bus_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hwregs_bridge_pkg.sv
// Shared types and constants for the CPU-to-hwregs bus bridge.
package hwregs_bridge_pkg;

  localparam logic [15:0] HWREGS_BASE = 16'hE000;

  // One buffered CPU request; bad marks an address outside the hwregs window.
  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [8:0]  tag;
    logic        bad;
  } hwregs_req_t;

  // One read response returned to the CPU.
  typedef struct packed {
    logic [8:0]  tag;
    logic [31:0] data;
  } hwregs_rsp_t;

  function automatic logic is_bad_addr(input logic [31:0] addr);
    return addr[31:16] != HWREGS_BASE;
  endfunction

endpackage

// File: rtl/bridge_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count.
module bridge_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointers (wrap naturally since DEPTH is a power of 2) and count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hwregs_bus_bridge.sv
// Buffers CPU requests, issues them in order to hwregs, and queues read
// responses so the CPU can backpressure a non-stallable hwregs block.
module hwregs_bus_bridge
  import hwregs_bridge_pkg::*;
#(
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  output logic        cpu_ready,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_wmask,
  input  logic [31:0] cpu_wdata,
  input  logic [8:0]  cpu_tag,
  output logic        cpu_rvalid,
  input  logic        cpu_rready,
  output logic [8:0]  cpu_rtag,
  output logic [31:0] cpu_rdata,
  output logic        hwregs_request,
  output logic        hwregs_write,
  output logic [15:0] hwregs_addr,
  output logic [3:0]  hwregs_wmask,
  output logic [31:0] hwregs_wdata,
  input  logic        hwregs_rvalid,
  input  logic [8:0]  hwregs_rtag,
  input  logic [31:0] hwregs_rdata,
  output logic        protocol_error
);

  localparam int unsigned QCW = $clog2(REQ_DEPTH + 1);
  localparam int unsigned RCW = $clog2(RSP_DEPTH + 1);
  localparam logic [RCW:0] RSP_LIMIT = (RCW + 1)'(RSP_DEPTH);

  hwregs_req_t    req_in, req_head;
  logic           req_push, req_pop, req_full, req_empty;
  logic [QCW-1:0] req_count;
  hwregs_rsp_t    rsp_in, rsp_head;
  logic           rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [RCW-1:0] rsp_count;
  logic           unused_status;

  // Stage 1 is the hwregs output register, stage 2 the cycle hwregs answers.
  logic        req_q, write_q;
  logic [15:0] addr_q;
  logic [3:0]  wmask_q;
  logic [31:0] wdata_q, wdata_d;
  logic        s1_good_rd_q, s1_bad_rd_q, s2_good_rd_q, s2_bad_rd_q;
  logic [8:0]  s1_bad_tag_q, s2_bad_tag_q;
  logic        perr_q;

  logic [1:0]   inflight;
  logic [RCW:0] credit_sum;
  logic         rd_credit_ok, issue_good, issue_bad_rd;

  assign req_in = '{write: cpu_write, addr: cpu_addr[15:0], wmask: cpu_wmask,
                    wdata: cpu_wdata, tag: cpu_tag, bad: is_bad_addr(cpu_addr)};
  assign cpu_ready = reset_n && !req_full;
  assign req_push  = cpu_req && cpu_ready;

  bridge_fifo #(.WIDTH($bits(hwregs_req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk_i(clock), .rst_ni(reset_n), .push_i(req_push), .wdata_i(req_in),
    .pop_i(req_pop), .rdata_o(req_head), .full_o(req_full),
    .empty_o(req_empty), .count_o(req_count)
  );

  // Reads in flight (either pipeline stage, good or bad) reserve response slots.
  assign inflight   = {1'b0, s1_good_rd_q | s1_bad_rd_q} + {1'b0, s2_good_rd_q | s2_bad_rd_q};
  assign credit_sum = {1'b0, rsp_count} + (RCW + 1)'(inflight);

  // Issue decision: writes always go, reads wait for a response credit.
  always_comb begin
    rd_credit_ok = (credit_sum < RSP_LIMIT);
    req_pop      = !req_empty && (req_head.write || rd_credit_ok);
    issue_good   = req_pop && !req_head.bad;
    issue_bad_rd = req_pop && req_head.bad && !req_head.write;
    wdata_d      = req_head.write ? req_head.wdata : {23'b0, req_head.tag};
  end

  // Output register, latency-matching pipeline and sticky protocol flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q        <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wmask_q      <= '0;
      wdata_q      <= '0;
      s1_good_rd_q <= 1'b0;
      s1_bad_rd_q  <= 1'b0;
      s1_bad_tag_q <= '0;
      s2_good_rd_q <= 1'b0;
      s2_bad_rd_q  <= 1'b0;
      s2_bad_tag_q <= '0;
      perr_q       <= 1'b0;
    end else begin
      req_q <= issue_good;
      if (issue_good) begin
        write_q <= req_head.write;
        addr_q  <= req_head.addr;
        wmask_q <= req_head.wmask;
        wdata_q <= wdata_d;
      end
      s1_good_rd_q <= issue_good && !req_head.write;
      s1_bad_rd_q  <= issue_bad_rd;
      s1_bad_tag_q <= req_head.tag;
      s2_good_rd_q <= s1_good_rd_q;
      s2_bad_rd_q  <= s1_bad_rd_q;
      s2_bad_tag_q <= s1_bad_tag_q;
      if (hwregs_rvalid && !s2_good_rd_q) perr_q <= 1'b1;
    end
  end

  assign hwregs_request = req_q;
  assign hwregs_write   = write_q;
  assign hwregs_addr    = addr_q;
  assign hwregs_wmask   = wmask_q;
  assign hwregs_wdata   = wdata_q;
  assign protocol_error = perr_q;

  // Only one entry issues per cycle, so a local bad-read return and a
  // hwregs response can never land in the same cycle.
  assign rsp_push = (hwregs_rvalid && s2_good_rd_q) || s2_bad_rd_q;
  assign rsp_in   = s2_bad_rd_q ? '{tag: s2_bad_tag_q, data: 32'h0}
                                : '{tag: hwregs_rtag, data: hwregs_rdata};
  assign rsp_pop  = cpu_rvalid && cpu_rready;

  bridge_fifo #(.WIDTH($bits(hwregs_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i(clock), .rst_ni(reset_n), .push_i(rsp_push), .wdata_i(rsp_in),
    .pop_i(rsp_pop), .rdata_o(rsp_head), .full_o(rsp_full),
    .empty_o(rsp_empty), .count_o(rsp_count)
  );

  assign cpu_rvalid = !rsp_empty;
  assign cpu_rtag   = rsp_head.tag;
  assign cpu_rdata  = rsp_head.data;

  assign unused_status = ^{req_count, rsp_full};

endmodule

// File: tb/tb_hwregs_bus_bridge.sv
// Randomized and directed bench for hwregs_bus_bridge with a queue-based
// reference model and a behavioural hwregs responder.
module tb_hwregs_bus_bridge;

  typedef struct { logic [8:0] tag; logic [31:0] data; } rsp_e;
  typedef struct { logic write; logic [15:0] addr; logic [3:0] wmask; logic [31:0] wdata; } iss_e;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_write = 1'b0, cpu_rready = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_wmask = '0;
  logic [8:0]  cpu_tag = '0;
  logic        cpu_ready, cpu_rvalid;
  logic [8:0]  cpu_rtag;
  logic [31:0] cpu_rdata;
  logic        hwregs_request, hwregs_write;
  logic [15:0] hwregs_addr;
  logic [3:0]  hwregs_wmask;
  logic [31:0] hwregs_wdata;
  logic        hw_rv = 1'b0;
  logic [8:0]  hw_rtag = '0;
  logic [31:0] hw_rdata = '0;
  logic        protocol_error;

  int   vectors = 0, miscompares = 0;
  int   cyc = 0, iss_cyc = -1, rv_cyc = -1;
  int   n_iss = 0, n_rd = 0, n_rsp = 0;
  bit   acc_last = 0, saw_not_ready = 0;
  rsp_e exp_rsp[$];
  iss_e exp_iss[$];

  hwregs_bus_bridge #(.REQ_DEPTH(4), .RSP_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wmask(cpu_wmask), .cpu_wdata(cpu_wdata),
    .cpu_tag(cpu_tag), .cpu_rvalid(cpu_rvalid), .cpu_rready(cpu_rready),
    .cpu_rtag(cpu_rtag), .cpu_rdata(cpu_rdata),
    .hwregs_request(hwregs_request), .hwregs_write(hwregs_write),
    .hwregs_addr(hwregs_addr), .hwregs_wmask(hwregs_wmask),
    .hwregs_wdata(hwregs_wdata), .hwregs_rvalid(hw_rv),
    .hwregs_rtag(hw_rtag), .hwregs_rdata(hw_rdata),
    .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  // Register contents the behavioural hwregs returns for an address.
  function automatic logic [31:0] hw_data(input logic [15:0] a);
    return {16'h0, a ^ 16'h015D};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input logic w, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d, input logic [8:0] t);
    cpu_req = 1'b1; cpu_write = w; cpu_addr = a; cpu_wmask = m; cpu_wdata = d; cpu_tag = t;
  endtask

  // One clock: update model from this cycle's handshakes, then advance.
  task automatic tick();
    bit   good, pend;
    rsp_e r;
    iss_e e;
    logic [8:0]  ptag;
    logic [31:0] pdata;
    pend = 0; ptag = '0; pdata = '0;
    acc_last = cpu_req && cpu_ready;
    if (!cpu_ready) saw_not_ready = 1;
    if (acc_last) begin
      good = (cpu_addr[31:16] == 16'hE000);
      if (!cpu_write) begin
        r.tag = cpu_tag; r.data = good ? hw_data(cpu_addr[15:0]) : 32'h0;
        exp_rsp.push_back(r);
      end
      if (good) begin
        e.write = cpu_write; e.addr = cpu_addr[15:0]; e.wmask = cpu_wmask;
        e.wdata = cpu_write ? cpu_wdata : {23'h0, cpu_tag};
        exp_iss.push_back(e);
      end
    end
    if (cpu_rvalid && rv_cyc < 0) rv_cyc = cyc;
    if (cpu_rvalid && cpu_rready) begin
      n_rsp++;
      if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        r = exp_rsp.pop_front();
        chk("rsp_tag", cpu_rtag, r.tag);
        chk("rsp_data", cpu_rdata, r.data);
      end
    end
    if (hwregs_request) begin
      n_iss++;
      if (iss_cyc < 0) iss_cyc = cyc;
      if (!hwregs_write) begin
        n_rd++; pend = 1; ptag = hwregs_wdata[8:0]; pdata = hw_data(hwregs_addr);
      end
      if (exp_iss.size() == 0) chk("iss_unexpected", 1, 0);
      else begin
        e = exp_iss.pop_front();
        chk("iss_write", hwregs_write, e.write);
        chk("iss_addr", hwregs_addr, e.addr);
        chk("iss_wdata", hwregs_wdata, e.wdata);
        if (e.write) chk("iss_wmask", hwregs_wmask, e.wmask);
      end
    end
    @(posedge clock); #1;
    cyc++;
    hw_rv = pend; hw_rtag = ptag; hw_rdata = pdata;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] d, input logic [8:0] t);
    set_req(w, a, m, d, t);
    for (int k = 0; k < 50; k++) begin
      tick();
      if (acc_last) break;
    end
    cpu_req = 1'b0;
    chk("send_accepted", acc_last, 1);
  endtask

  task automatic drain();
    cpu_req = 1'b0; cpu_rready = 1'b1;
    for (int k = 0; k < 100 && (exp_rsp.size() != 0 || exp_iss.size() != 0); k++) tick();
    repeat (3) tick();
    chk("drain_rsp_left", exp_rsp.size(), 0);
    chk("drain_iss_left", exp_iss.size(), 0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_cpu_ready"}, cpu_ready, 0);
    chk({p, "_cpu_rvalid"}, cpu_rvalid, 0);
    chk({p, "_req"}, hwregs_request, 0);
    chk({p, "_write"}, hwregs_write, 0);
    chk({p, "_addr"}, hwregs_addr, 0);
    chk({p, "_wmask"}, hwregs_wmask, 0);
    chk({p, "_wdata"}, hwregs_wdata, 0);
    chk({p, "_perr"}, protocol_error, 0);
  endtask

  initial begin
    int nxt, base_rd, base_rsp, base_iss;

    repeat (2) @(posedge clock);
    #1;
    chk_reset("rst");
    reset_n = 1'b1;
    cpu_rready = 1'b1;
    tick();

    // Single good write.
    base_iss = n_iss; base_rsp = n_rsp; rv_cyc = -1;
    send(1'b1, 32'hE000_0004, 4'hF, 32'h0000_03FF, 9'h0);
    repeat (6) tick();
    chk("wr_issue_count", n_iss - base_iss, 1);
    chk("wr_no_rvalid", rv_cyc < 0, 1);
    chk("wr_no_rsp", n_rsp - base_rsp, 0);

    // Single good read, latency check.
    iss_cyc = -1; rv_cyc = -1; base_rsp = n_rsp;
    set_req(1'b0, 32'hE000_0008, 4'h0, 32'h0, 9'h1A5);
    nxt = cyc;
    tick();
    cpu_req = 1'b0;
    chk("rd_accepted", acc_last, 1);
    repeat (8) tick();
    chk("rd_issue_latency", iss_cyc - nxt, 2);
    chk("rd_rvalid_latency", rv_cyc - nxt, 4);
    chk("rd_rsp_count", n_rsp - base_rsp, 1);

    // Eight back-to-back reads while the CPU withholds rready.
    cpu_rready = 1'b0; saw_not_ready = 0; nxt = 0;
    base_rd = n_rd; base_rsp = n_rsp;
    for (int c = 0; c < 20; c++) begin
      if (nxt < 8) set_req(1'b0, 32'hE000_0000 + 32'(nxt * 4), 4'h0, 32'h0, 9'(nxt));
      else cpu_req = 1'b0;
      tick();
      if (acc_last) nxt++;
    end
    cpu_req = 1'b0;
    chk("bp_reads_issued", n_rd - base_rd, 4);
    chk("bp_all_accepted", nxt, 8);
    chk("bp_ready_dropped", saw_not_ready, 1);
    chk("bp_no_rsp", n_rsp - base_rsp, 0);
    drain();
    chk("bp_rsp_count", n_rsp - base_rsp, 8);

    // Bad read sandwiched between two good reads.
    base_rd = n_rd; base_rsp = n_rsp;
    set_req(1'b0, 32'hE000_0010, 4'h0, 32'h0, 9'd6); tick();
    set_req(1'b0, 32'h1234_0000, 4'h0, 32'h0, 9'd7); tick();
    set_req(1'b0, 32'hE000_0014, 4'h0, 32'h0, 9'd8); tick();
    cpu_req = 1'b0;
    drain();
    chk("bad_rd_hw_reads", n_rd - base_rd, 2);
    chk("bad_rd_rsp_count", n_rsp - base_rsp, 3);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      logic [31:0] a;
      cpu_rready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6) begin
        a = $urandom;
        if ($urandom_range(0, 9) < 8) a[31:16] = 16'hE000;
        else if (a[31:16] == 16'hE000) a[31:16] = 16'h1234;
        set_req(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, 9'($urandom));
      end else cpu_req = 1'b0;
      tick();
    end
    drain();
    chk("rand_perr", protocol_error, 0);

    // Spurious response with nothing issued.
    base_rsp = n_rsp;
    hw_rv = 1'b1; hw_rtag = 9'h055; hw_rdata = 32'hDEAD_BEEF;
    tick();
    chk("spur_perr", protocol_error, 1);
    chk("spur_no_rvalid", cpu_rvalid, 0);
    repeat (3) tick();
    chk("spur_perr_sticky", protocol_error, 1);
    chk("spur_no_rsp", n_rsp - base_rsp, 0);
    reset_n = 1'b0;
    #1;
    chk_reset("rst2");
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", cpu_ready, 1);

    // Reset while a read is outstanding; its late response is unexpected.
    set_req(1'b0, 32'hE000_0020, 4'h0, 32'h0, 9'h0AA);
    tick();
    cpu_req = 1'b0;
    tick();
    chk("mid_req_visible", hwregs_request, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_req_cleared", hwregs_request, 0);
    reset_n = 1'b1;
    exp_rsp.delete(); exp_iss.delete();
    hw_rv = 1'b1; hw_rtag = 9'h0AA; hw_rdata = hw_data(16'h0020);
    tick();
    chk("late_rsp_perr", protocol_error, 1);
    chk("late_rsp_no_rvalid", cpu_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
